ps2_cmd_arbiter: RTL

Shares the single PS/2 mouse transmitter/receiver pair between two command sources: the mouse master state machine (requester 0) and the processor bus command port (requester 1, e.g. sample-rate and resolution writes). It sequences each command byte as send, wait for transmit completion, then wait for the device acknowledge. It retries on resend requests and reports done or error back to the owning requester. It sits between the requesters and the transmitter/receiver, inside the mouse transceiver.

---
 rtl/ps2_pkg.sv | 31 +++
 rtl/ps2_cmd_arbiter_if.sv | 39 +++
 rtl/ps2_arb_timer.sv | 29 ++
 rtl/ps2_cmd_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 mouse command path.
// Holds the arbiter state encoding, device response bytes and the
// receiver error codes used by ps2_cmd_arbiter.
package ps2_pkg;

  localparam int CNT_W   = 21;
  localparam int RETRY_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_WAIT_SENT = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_RELEASE   = 3'd4
  } arb_state_t;

  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERROR  = 8'hFC;

  localparam logic [1:0] RX_OK          = 2'b00;
  localparam logic [1:0] RX_PARITY_ERR  = 2'b01;
  localparam logic [1:0] RX_FRAME_ERR   = 2'b10;
  localparam logic [1:0] RX_TIMEOUT_ERR = 2'b11;

  // A dirty receive or an explicit resend request both ask for the byte again
  function automatic logic rx_needs_retry(input logic [1:0] code, input logic [7:0] data);
    return (code != RX_OK) || (data == PS2_RESEND);
  endfunction

endpackage

// File: rtl/ps2_cmd_arbiter_if.sv
// ps2_cmd_arbiter_if: requester, transmitter and receiver signals of the
// PS/2 command arbiter. The arbiter uses the slave modport; the
// surrounding transceiver (or a bench) uses the master modport.
interface ps2_cmd_arbiter_if;

  logic       REQ0;
  logic       REQ1;
  logic [7:0] BYTE0;
  logic [7:0] BYTE1;
  logic       DONE0;
  logic       DONE1;
  logic       ERR0;
  logic       ERR1;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT;
  logic       RX_EN_IN;
  logic       READ_ENABLE;
  logic       BYTE_READY;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BUSY;
  logic       OWNER;

  modport slave (
    input  REQ0, REQ1, BYTE0, BYTE1, BYTE_SENT, RX_EN_IN,
           BYTE_READY, BYTE_READ, BYTE_ERROR_CODE,
    output DONE0, DONE1, ERR0, ERR1, SEND_BYTE, BYTE_TO_SEND,
           READ_ENABLE, BUSY, OWNER
  );

  modport master (
    output REQ0, REQ1, BYTE0, BYTE1, BYTE_SENT, RX_EN_IN,
           BYTE_READY, BYTE_READ, BYTE_ERROR_CODE,
    input  DONE0, DONE1, ERR0, ERR1, SEND_BYTE, BYTE_TO_SEND,
           READ_ENABLE, BUSY, OWNER
  );

endinterface

// File: rtl/ps2_arb_timer.sv
// ps2_arb_timer: saturating timeout counter for the command arbiter.
// 'clear' zeroes the count; 'expired' flags count >= limit and is held
// low while clear is asserted so a stale count never fires.
module ps2_arb_timer
  import ps2_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  // Count up every cycle, stopping at all-ones instead of wrapping
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count != {CNT_W{1'b1}}) begin
      count <= count + 1'b1;
    end
  end

  assign expired = !clear && (count >= limit);

endmodule

// File: rtl/ps2_cmd_arbiter.sv
// ps2_cmd_arbiter: shares the PS/2 mouse transmitter/receiver between the
// mouse master FSM (requester 0) and the bus command port (requester 1).
// Each byte goes send -> wait transmit done -> wait device ack, with
// resend retries, and DONEx/ERRx reported back to the owner.
// Optional macro PS2_ARB_RR_EN: round-robin tie break instead of REQ0 priority.
module ps2_cmd_arbiter
  import ps2_pkg::*;
#(
  parameter int ACK_TIMEOUT = 2_000_000,
  parameter int TX_TIMEOUT  = 2_000_000,
  parameter int MAX_RETRY   = 2
) (
  input  logic                CLK,
  input  logic                RESET_N,
  ps2_cmd_arbiter_if.slave    bus
);

  arb_state_t         state;
  logic               owner_q;
  logic [7:0]         byte_q;
  logic [RETRY_W-1:0] retry_cnt;
  logic               rel_cnt;
  logic               send_q;
  logic               done0_q;
  logic               done1_q;
  logic               err0_q;
  logic               err1_q;
  logic               rd_en_q;
  logic               busy_q;
  logic               tmr_clr;
  logic               expired;
  logic [CNT_W-1:0]   tmr_limit;
  logic               grant;
  logic               fin_done;
  logic               fin_err;
  logic               can_retry;

`ifdef PS2_ARB_RR_EN
  logic last_owner;

  // Remember the last grant so the other requester wins the next tie
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      last_owner <= 1'b1;
    end else if (state == ST_IDLE && (bus.REQ0 || bus.REQ1)) begin
      last_owner <= grant;
    end
  end

  assign grant = (bus.REQ0 && bus.REQ1) ? ~last_owner : bus.REQ1;
`else
  assign grant = ~bus.REQ0;
`endif

  assign tmr_limit = (state == ST_WAIT_SENT) ? CNT_W'(TX_TIMEOUT) : CNT_W'(ACK_TIMEOUT);
  assign can_retry = retry_cnt < RETRY_W'(MAX_RETRY);

  ps2_arb_timer u_timer (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .clear   (tmr_clr),
    .limit   (tmr_limit),
    .expired (expired)
  );

  // Decide whether the current command finishes this cycle, and how
  always_comb begin
    fin_done = 1'b0;
    fin_err  = 1'b0;
    case (state)
      ST_WAIT_SENT: fin_err = !bus.BYTE_SENT && expired;
      ST_WAIT_ACK: begin
        if (bus.BYTE_READY) begin
          fin_done = (bus.BYTE_ERROR_CODE == RX_OK) && (bus.BYTE_READ == PS2_ACK);
          fin_err  = !fin_done &&
                     !(rx_needs_retry(bus.BYTE_ERROR_CODE, bus.BYTE_READ) && can_retry);
        end else begin
          fin_err = expired;
        end
      end
      default: ;
    endcase
  end

  // Command sequencer with all outputs registered alongside the state
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      owner_q   <= 1'b0;
      byte_q    <= 8'h00;
      retry_cnt <= '0;
      rel_cnt   <= 1'b0;
      send_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      tmr_clr   <= 1'b0;
    end else begin
      send_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      tmr_clr <= 1'b0;
      if (fin_done || fin_err) begin
        state   <= ST_RELEASE;
        rel_cnt <= 1'b0;
        rd_en_q <= 1'b0;
        tmr_clr <= 1'b1;
        done0_q <= fin_done && !owner_q;
        done1_q <= fin_done && owner_q;
        err0_q  <= fin_err && !owner_q;
        err1_q  <= fin_err && owner_q;
      end else begin
        case (state)
          ST_IDLE: begin
            rd_en_q <= bus.RX_EN_IN;
            if (bus.REQ0 || bus.REQ1) begin
              state     <= ST_SEND;
              owner_q   <= grant;
              byte_q    <= grant ? bus.BYTE1 : bus.BYTE0;
              retry_cnt <= '0;
              send_q    <= 1'b1;
              busy_q    <= 1'b1;
              rd_en_q   <= 1'b0;
              tmr_clr   <= 1'b1;
            end
          end
          ST_SEND: begin
            state   <= ST_WAIT_SENT;
            tmr_clr <= 1'b1;
          end
          ST_WAIT_SENT: begin
            if (bus.BYTE_SENT) begin
              state   <= ST_WAIT_ACK;
              rd_en_q <= 1'b1;
              tmr_clr <= 1'b1;
            end
          end
          ST_WAIT_ACK: begin
            if (bus.BYTE_READY) begin
              state     <= ST_SEND;
              retry_cnt <= retry_cnt + 1'b1;
              send_q    <= 1'b1;
              rd_en_q   <= 1'b0;
              tmr_clr   <= 1'b1;
            end
          end
          ST_RELEASE: begin
            if (rel_cnt) begin
              state   <= ST_IDLE;
              busy_q  <= 1'b0;
              rd_en_q <= bus.RX_EN_IN;
              tmr_clr <= 1'b1;
            end else begin
              rel_cnt <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.SEND_BYTE    = send_q;
  assign bus.BYTE_TO_SEND = byte_q;
  assign bus.DONE0        = done0_q;
  assign bus.DONE1        = done1_q;
  assign bus.ERR0         = err0_q;
  assign bus.ERR1         = err1_q;
  assign bus.READ_ENABLE  = rd_en_q;
  assign bus.BUSY         = busy_q;
  assign bus.OWNER        = owner_q;

endmodule
